xbar_slave_regbank: RTL



---
 rtl/xbar_slave_regbank.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/xbar_slave_regbank.sv
// xbar_slave_regbank: crossbar slave-port responder backed by a small bank of
// registers. A programmable number of wait states is inserted between request
// capture and the one-cycle ack, so slow slaves can be modelled. Out-of-range
// or misaligned addresses complete with s_err set and never change state.
module xbar_slave_regbank #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int REG_AW      = 3,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_req,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic                  s_cmd,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_ack,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_err,
  output logic                  busy
);

  localparam int NREGS = 1 << REG_AW;
  localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WS_C  = CW'(WAIT_STATES);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic          ZERO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // An address is usable only when word aligned and inside the bank.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    addr_err = (a[1:0] != 2'b00) ||
               (a[ADDR_WIDTH-1:REG_AW+2] != {(ADDR_WIDTH-REG_AW-2){1'b0}});
  endfunction

  state_t                  state_r;
  state_t                  next_s;
  logic [CW-1:0]           cnt_r;
  logic [REG_AW-1:0]       idx_r;
  logic                    cmd_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic                    err_r;
  logic [DATA_WIDTH-1:0]   regs_r [NREGS];

  logic                    ack_r;
  logic                    err_out_r;
  logic                    busy_r;
  logic [DATA_WIDTH-1:0]   rdata_r;

  // Transfer attributes as seen on the ACK-entry edge: live inputs when the
  // transfer goes straight from IDLE to ACK, the captured copy otherwise.
  logic [REG_AW-1:0]       cur_idx_s;
  logic                    cur_cmd_s;
  logic [DATA_WIDTH-1:0]   cur_wdata_s;
  logic                    cur_err_s;
  logic                    enter_ack_s;

  // Next-state decode and selection of the transfer being completed.
  always_comb begin
    next_s      = state_r;
    cur_idx_s   = idx_r;
    cur_cmd_s   = cmd_r;
    cur_wdata_s = wdata_r;
    cur_err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        cur_idx_s   = s_addr[REG_AW+1:2];
        cur_cmd_s   = s_cmd;
        cur_wdata_s = s_wdata;
        cur_err_s   = addr_err(s_addr);
        if (s_req) begin
          if (ZERO_WAIT) begin
            next_s = ST_ACK;
          end else begin
            next_s = ST_WAIT;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= ONE_C) begin
          next_s = ST_ACK;
        end else begin
          next_s = ST_WAIT;
        end
      end
      ST_ACK: begin
        next_s = ST_IDLE;
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
    enter_ack_s = (next_s == ST_ACK) && (state_r != ST_ACK);
  end

  // State register, request capture and wait-state countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      idx_r   <= {REG_AW{1'b0}};
      cmd_r   <= 1'b0;
      wdata_r <= {DATA_WIDTH{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= next_s;
      case (state_r)
        ST_IDLE: begin
          if (s_req) begin
            cnt_r   <= WS_C;
            idx_r   <= s_addr[REG_AW+1:2];
            cmd_r   <= s_cmd;
            wdata_r <= s_wdata;
            err_r   <= addr_err(s_addr);
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - ONE_C;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Register bank commit and registered bus outputs, updated on ACK entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
      ack_r     <= 1'b0;
      err_out_r <= 1'b0;
      busy_r    <= 1'b0;
      rdata_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      if (enter_ack_s && cur_cmd_s && !cur_err_s) begin
        regs_r[cur_idx_s] <= cur_wdata_s;
      end
      if (enter_ack_s) begin
        if (cur_err_s) begin
          rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (cur_cmd_s) begin
          rdata_r <= cur_wdata_s;
        end else begin
          rdata_r <= regs_r[cur_idx_s];
        end
      end
      ack_r     <= enter_ack_s;
      err_out_r <= enter_ack_s & cur_err_s;
      busy_r    <= (next_s != ST_IDLE);
    end
  end

  assign s_ack   = ack_r;
  assign s_err   = err_out_r;
  assign busy    = busy_r;
  assign s_rdata = rdata_r;

endmodule
